// File: rtl/out_arbiter_pkg.sv
// Shared definitions for the display-write arbiter: FSM encoding, slot count
// and default datapath widths.
package out_arbiter_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int NSLOT      = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_SEL_W  = 4;

endpackage

// File: rtl/out_arbiter_rr_pick.sv
// Stateless round-robin picker: the first set request at or above ptr
// (wrapping modulo NREQ) wins.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    any
);

  localparam int IDX_W = $clog2(NREQ);

  logic [IDX_W-1:0] cand;

  // NREQ is a power of two, so the candidate index wraps by truncation.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      cand = ptr + IDX_W'(off);
      if (!any && req[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/out_arbiter.sv
// Shares the display write port among NREQ requesters; after reset or clear
// it first walks all slots writing INIT_VAL, then arbitrates round-robin.
module out_arbiter
  import out_arbiter_pkg::*;
#(
  parameter int                NREQ     = 4,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                SEL_W    = DEF_SEL_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  input  logic [NREQ*SEL_W-1:0]    req_sel,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     clear,
  output logic                     busy,
  output logic [DATA_W-1:0]        outval1,
  output logic [SEL_W-1:0]         outsel,
  output logic                     outdisplay,
  output logic [$clog2(NREQ)-1:0]  grant_id
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(NSLOT);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic [NREQ-1:0]   pick_grant;
  logic              pick_any;
  logic              init_wr;
  logic              xfer;
  logic [DATA_W-1:0] win_data;
  logic [SEL_W-1:0]  win_sel;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (req_valid),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  always_comb begin
    win_data = '0;
    win_sel  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_grant[i]) begin
        win_data = req_data[i*DATA_W +: DATA_W];
        win_sel  = req_sel[i*SEL_W +: SEL_W];
      end
    end
  end

  // clear inside INIT only rewinds the counter; the slot addressed this cycle is still written.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    req_ready = '0;
    init_wr   = 1'b0;
    xfer      = 1'b0;
    case (state)
      ST_INIT: begin
        init_wr = 1'b1;
        if (clear) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_W'(NSLOT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_RUN;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (clear) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end else begin
          req_ready = pick_grant;
          xfer      = pick_any;
        end
      end
      default: state_nxt = ST_INIT;
    endcase
  end

  assign busy = (state == ST_INIT);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= ST_INIT;
      cnt        <= '0;
      ptr        <= '0;
      outdisplay <= 1'b0;
      outval1    <= '0;
      outsel     <= '0;
      grant_id   <= '0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      outdisplay <= init_wr | xfer;
      if (init_wr) begin
        outval1 <= INIT_VAL;
        outsel  <= SEL_W'(cnt);
      end else if (xfer) begin
        outval1  <= win_data;
        outsel   <= win_sel;
        grant_id <= pick_idx;
        ptr      <= pick_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_out_arbiter.sv
// Self-checking bench for out_arbiter: table-driven grant vectors plus
// hand-written clear/reset sequences, with a write scoreboard.
module tb_out_arbiter;

  localparam int                NREQ     = 4;
  localparam int                DATA_W   = 16;
  localparam int                SEL_W    = 4;
  localparam logic [DATA_W-1:0] INIT_VAL = 16'h0000;

  logic                   clock = 1'b0;
  logic                   reset = 1'b0;
  logic [NREQ-1:0]        req_valid = '0;
  logic [NREQ*DATA_W-1:0] req_data = '0;
  logic [NREQ*SEL_W-1:0]  req_sel = '0;
  logic [NREQ-1:0]        req_ready;
  logic                   clear = 1'b0;
  logic                   busy;
  logic [DATA_W-1:0]      outval1;
  logic [SEL_W-1:0]       outsel;
  logic                   outdisplay;
  logic [1:0]             grant_id;

  out_arbiter #(
    .NREQ     (NREQ),
    .DATA_W   (DATA_W),
    .SEL_W    (SEL_W),
    .INIT_VAL (INIT_VAL)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_sel    (req_sel),
    .req_ready  (req_ready),
    .clear      (clear),
    .busy       (busy),
    .outval1    (outval1),
    .outsel     (outsel),
    .outdisplay (outdisplay),
    .grant_id   (grant_id)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic              init;
    logic [SEL_W-1:0]  sel;
    logic [DATA_W-1:0] val;
    logic [1:0]        gid;
  } exp_t;

  typedef struct {
    logic [NREQ-1:0] valid;
    logic [NREQ-1:0] ready;
  } vec_t;

  exp_t q[$];
  exp_t me;
  int   errors = 0;
  int   checks = 0;
  logic mon_en = 1'b0;
  logic [SEL_W-1:0]  last_sel = '0;
  logic [DATA_W-1:0] last_val = '0;
  logic [1:0]        last_gid = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each write pushed at cycle N must appear on the display port at cycle N+1.
  always @(negedge clock) begin
    if (mon_en) begin
      if (q.size() > 0) begin
        me = q.pop_front();
        if (!me.init) last_gid = me.gid;
        chk("write strobe", 32'(outdisplay), 32'd1);
        chk("write sel", 32'(outsel), 32'(me.sel));
        chk("write val", 32'(outval1), 32'(me.val));
        chk("write gid", 32'(grant_id), 32'(last_gid));
        last_sel = me.sel;
        last_val = me.val;
      end else begin
        chk("idle strobe", 32'(outdisplay), 32'd0);
        chk("hold sel", 32'(outsel), 32'(last_sel));
        chk("hold val", 32'(outval1), 32'(last_val));
        chk("hold gid", 32'(grant_id), 32'(last_gid));
      end
    end
  end

  task automatic set_pattern(input int k);
    for (int i = 0; i < NREQ; i++) begin
      req_data[i*DATA_W +: DATA_W] = {4'hD, 4'(i), 8'(k)};
      req_sel[i*SEL_W +: SEL_W]    = 4'(i*3 + k);
    end
  endtask

  task automatic step(input logic [NREQ-1:0] v, input logic [NREQ-1:0] exp_rdy,
                      input logic clr, input logic exp_busy,
                      input logic init_wr, input logic [SEL_W-1:0] init_sel,
                      input string tag);
    exp_t e;
    req_valid = v;
    clear     = clr;
    #1;
    chk({tag, " ready"}, 32'(req_ready), 32'(exp_rdy));
    chk({tag, " busy"}, 32'(busy), 32'(exp_busy));
    if (init_wr) begin
      e.init = 1'b1; e.sel = init_sel; e.val = INIT_VAL; e.gid = '0;
      q.push_back(e);
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (exp_rdy[i]) begin
          e.init = 1'b0;
          e.sel  = req_sel[i*SEL_W +: SEL_W];
          e.val  = req_data[i*DATA_W +: DATA_W];
          e.gid  = 2'(i);
          q.push_back(e);
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic run_init(input logic [NREQ-1:0] v, input int n, input int clr_at, input string tag);
    for (int k = 0; k < n; k++)
      step(v, '0, (k == clr_at), 1'b1, 1'b1, 4'(k), tag);
  endtask

  vec_t tbl[18];

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b1111, 4'b0001};
    tbl[1]  = '{4'b1111, 4'b0010};
    tbl[2]  = '{4'b1111, 4'b0100};
    tbl[3]  = '{4'b1111, 4'b1000};
    tbl[4]  = '{4'b1111, 4'b0001};
    tbl[5]  = '{4'b1111, 4'b0010};
    tbl[6]  = '{4'b1111, 4'b0100};
    tbl[7]  = '{4'b1111, 4'b1000};
    tbl[8]  = '{4'b0000, 4'b0000};
    tbl[9]  = '{4'b0110, 4'b0010};
    tbl[10] = '{4'b0110, 4'b0100};
    tbl[11] = '{4'b0110, 4'b0010};
    tbl[12] = '{4'b1001, 4'b1000};
    tbl[13] = '{4'b1001, 4'b0001};
    tbl[14] = '{4'b1001, 4'b1000};
    tbl[15] = '{4'b0100, 4'b0100};
    tbl[16] = '{4'b1100, 4'b1000};
    tbl[17] = '{4'b0000, 4'b0000};

    // Reset state, with requests pending that must not be accepted.
    req_valid = 4'b1111;
    set_pattern(0);
    #3;
    chk("rst strobe", 32'(outdisplay), 32'd0);
    chk("rst sel", 32'(outsel), 32'd0);
    chk("rst val", 32'(outval1), 32'd0);
    chk("rst gid", 32'(grant_id), 32'd0);
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst ready", 32'(req_ready), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;

    run_init(4'b1111, 16, -1, "init0");

    for (int t = 0; t < 18; t++) begin
      set_pattern(t + 1);
      step(tbl[t].valid, tbl[t].ready, 1'b0, 1'b0, 1'b0, '0, $sformatf("vec%0d", t));
    end

    // Steer the pointer to 2, then a lone req1 must still win immediately.
    set_pattern(40);
    step(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, '0, "ptr2");
    req_data[1*DATA_W +: DATA_W] = 16'hBEEF;
    req_sel[1*SEL_W +: SEL_W]    = 4'h5;
    step(4'b0010, 4'b0010, 1'b0, 1'b0, 1'b0, '0, "beef");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, '0, "idle1");

    // clear beats a pending request, then INIT replays and req0 wins first.
    set_pattern(50);
    step(4'b0001, 4'b0000, 1'b1, 1'b0, 1'b0, '0, "clr_run");
    run_init(4'b0001, 16, -1, "init1");
    step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0, '0, "post_clr");

    // Asynchronous reset while a write strobe is on the port.
    set_pattern(60);
    req_valid = 4'b0001;
    #1;
    chk("pre_rst ready", 32'(req_ready), 32'b0001);
    mon_en = 1'b0;
    @(posedge clock);
    #2;
    chk("pre_rst strobe", 32'(outdisplay), 32'd1);
    chk("pre_rst val", 32'(outval1), 32'({4'hD, 4'h0, 8'd60}));
    reset = 1'b0;
    #1;
    chk("async strobe", 32'(outdisplay), 32'd0);
    chk("async val", 32'(outval1), 32'd0);
    chk("async busy", 32'(busy), 32'd1);
    chk("async ready", 32'(req_ready), 32'd0);
    q.delete();
    last_sel = '0;
    last_val = '0;
    last_gid = '0;
    req_valid = '0;
    @(negedge clock);
    @(negedge clock);
    reset  = 1'b1;
    mon_en = 1'b1;

    // clear at counter 9: 10 writes, then a full 16-slot pass.
    run_init(4'b1111, 10, 9, "init2a");
    run_init(4'b1111, 16, -1, "init2b");
    set_pattern(70);
    step(4'b0100, 4'b0100, 1'b0, 1'b0, 1'b0, '0, "post_rst");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, '0, "idle2");
    step(4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, '0, "idle3");
    chk("queue drained", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/out_arbiter.md
OUT_ARBITER -- requirements
Module: out_arbiter

Interface
REQ-001 Parameter NREQ, 4: number of requesters sharing the display write port; power of two, 2..8.
REQ-002 Parameter DATA_W, 16: write-data width per requester.
REQ-003 Parameter SEL_W, 4: slot-select width (16 slots: bit0 = bank, bits[3:1] = digit row).
REQ-004 Parameter INIT_VAL, 16'h0000: value written to every slot by the init sequence.
REQ-005 clock  in  1  sole clock, rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 req_valid  in  NREQ  per-requester write request.
REQ-008 req_data  in  NREQ*DATA_W  packed data; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-009 req_sel  in  NREQ*SEL_W  packed slot select; same packing rule.
REQ-010 req_ready  out  NREQ  one-hot-or-zero accept; a transfer occurs on a cycle where valid[i] and ready[i] are both 1.
REQ-011 clear  in  1  single-cycle pulse; re-runs the init sequence.
REQ-012 busy  out  1  high while the init sequence runs.
REQ-013 outval1  out  DATA_W  registered write data to the display block.
REQ-014 outsel  out  SEL_W  registered slot select to the display block.
REQ-015 outdisplay  out  1  registered one-cycle write strobe to the display block.
REQ-016 grant_id  out  clog2(NREQ)  index of the last accepted requester; debug only.

Function
REQ-017 The FSM SHALL have two states: INIT and RUN.
REQ-018 In INIT, a 4-bit counter SHALL step 0..15, one slot per cycle, driving outsel=counter, outval1=INIT_VAL, outdisplay=1 on the following cycle.
REQ-019 INIT SHALL last exactly 16 cycles, then transition to RUN; busy=1 throughout INIT and 0 in RUN.
REQ-020 req_ready SHALL be all-zero in INIT.
REQ-021 In RUN, req_ready SHALL be combinational: the first requester with valid=1 searching from rr_ptr upward modulo NREQ gets ready=1; all others get 0.
REQ-022 rr_ptr SHALL update to (winner+1) mod NREQ on each transfer and otherwise hold.
REQ-023 On a transfer, outval1/outsel SHALL take the winner's data/select and outdisplay SHALL be 1 on the next cycle (latency 1); grant_id SHALL take the winner index.
REQ-024 With no transfer and not in INIT, outdisplay SHALL be 0 next cycle; outval1, outsel, grant_id SHALL hold.
REQ-025 Throughput SHALL be one transfer per cycle with no bubbles between back-to-back grants.
REQ-026 clear in RUN SHALL force req_ready to 0 that cycle (clear beats any grant) and enter INIT with counter=0 next cycle.
REQ-027 clear during INIT SHALL restart the counter at 0; the slot written in that same cycle still completes.
REQ-028 Counter wrap 15->0 SHALL coincide with the INIT->RUN transition; no 17th write.
REQ-029 Requesters SHALL hold valid/data/select stable until accepted; the block does not buffer unaccepted requests.

Reset
REQ-030 On reset low, the block SHALL enter INIT, counter=0, rr_ptr=0, outdisplay=0, outval1=0, outsel=0, grant_id=0, busy=1.
REQ-031 On reset deassertion, the init sequence SHALL begin on the first clock edge; the first outdisplay appears one cycle later.
REQ-032 Reset asserted mid-transfer SHALL drop outdisplay immediately (asynchronously); the interrupted write is lost.

Structure
REQ-033 Shared package holds: state encoding (INIT/RUN), NSLOT=16, and default DATA_W/SEL_W.
REQ-034 Round-robin selection SHALL be a sub-module rr_pick (inputs: req vector, ptr; output: one-hot grant, index, any) with no state.

Verification
REQ-035 Reset release -> 16 consecutive outdisplay pulses with outsel 0..15, outval1=0000, busy falls after the 16th, req_ready=0 throughout.
REQ-036 RUN, req_valid=4'b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one outdisplay per cycle.
REQ-037 RUN, rr_ptr=2, only req1 valid with data 16'hBEEF, sel 4'h5 -> ready[1] same cycle; next cycle outval1=BEEF, outsel=5, outdisplay=1, grant_id=1.
REQ-038 clear pulse with req_valid=4'b0001 -> req_ready=0 that cycle, 16 INIT writes follow, req0 accepted on the first RUN cycle.
REQ-039 clear at INIT counter=9 -> counter restarts at 0; 26 INIT writes total since reset, then RUN.
REQ-040 reset pulled low mid-RUN with outdisplay=1 -> outdisplay=0 before the next clock edge; the INIT sequence repeats after release.
